// File: rtl/display_pkg.sv
// Shared display definitions: requester count, arbiter states, segment
// patterns (bit 6..0 = g..a, 1 = lit) and the lowest-index request picker.
package display_pkg;

   localparam int NREQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWITCH,
      ST_SHOW,
      ST_FLASH
   } state_t;

   localparam logic [6:0] SEG_PATTERN [10] = '{
      7'b0111111,  // 0
      7'b0000110,  // 1
      7'b1011011,  // 2
      7'b1001111,  // 3
      7'b1100110,  // 4
      7'b1101101,  // 5
      7'b1111101,  // 6
      7'b0000111,  // 7
      7'b1111111,  // 8
      7'b1101111   // 9
   };

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_ALL   = 7'b1111111;
   localparam logic [3:0] ANODE_OFF = 4'b1111;

   // One-hot of the lowest set request bit, or zero when nothing is requested.
   function automatic logic [NREQ-1:0] lowest_req(input logic [NREQ-1:0] r);
      return r & (~r + NREQ'(1));
   endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bus between the service blocks (master side) and the display arbiter
// (slave side): requests, digit data, blink masks, alarm override, and the
// grant/display outputs.
interface display_arbiter_if;
   import display_pkg::*;

   logic [NREQ-1:0]    req;
   logic [16*NREQ-1:0] num;
   logic [4*NREQ-1:0]  blink_sel;
   logic               alarm_flash;
   logic [NREQ-1:0]    grant;
   logic [3:0]         anode;
   logic [6:0]         eSeg;
   logic               frame_done;

   modport master (
      output req, num, blink_sel, alarm_flash,
      input  grant, anode, eSeg, frame_done
   );

   modport slave (
      input  req, num, blink_sel, alarm_flash,
      output grant, anode, eSeg, frame_done
   );

endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to seven-segment pattern; codes above 9 are blank.
module bcd_seg_decode
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup with blank fallback for non-decimal codes
   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) begin
         seg = SEG_PATTERN[bcd];
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// Shared 4-digit display owner: sticky lowest-index arbitration switched only
// at frame boundaries with one blank frame per owner change, digit scan,
// per-digit blink and the alarm full-display flash.
module display_arbiter
   import display_pkg::*;
#(
   parameter int SCAN_DIV     = 65536,
   parameter int BLINK_FRAMES = 64
) (
   input  logic             clk,
   input  logic             reset,
   display_arbiter_if.slave bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0]   presc;
   logic [1:0]      digit;
   logic [BW-1:0]   blink_cnt;
   logic            blink_phase;
   state_t          state, state_next;
   logic [NREQ-1:0] grant_q, grant_next;
   logic            digit_end, boundary, owner_kept;
   logic [15:0]     owner_num;
   logic [3:0]      owner_blink, owner_nib, anode_next, anode_q;
   logic [6:0]      nib_seg, seg_next, seg_q;

   assign digit_end  = (presc == PRESC_LAST);
   assign boundary   = digit_end && (digit == 2'd3);
   assign owner_kept = |(bus.req & grant_q);

   // Digit scan: prescaler per digit, digit index wraps 3 -> 0
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         digit <= 2'd0;
      end else if (digit_end) begin
         presc <= '0;
         digit <= digit + 2'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Blink phase flips after every BLINK_FRAMES frame boundaries
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (boundary) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   // Arbiter state and current owner
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         grant_q <= '0;
      end else begin
         state   <= state_next;
         grant_q <= grant_next;
      end
   end

   // Next state and owner, evaluated only at frame boundaries; the alarm
   // override wins over any request change, and an owner is never preempted
   always_comb begin
      state_next = state;
      grant_next = grant_q;
      if (boundary) begin
         case (state)
            ST_IDLE: begin
               if (bus.alarm_flash) begin
                  state_next = ST_FLASH;
               end else if (|bus.req) begin
                  grant_next = lowest_req(bus.req);
                  state_next = ST_SWITCH;
               end
            end
            ST_SWITCH, ST_SHOW: begin
               if (bus.alarm_flash) begin
                  grant_next = '0;
                  state_next = ST_FLASH;
               end else if (!owner_kept) begin
                  grant_next = lowest_req(bus.req);
                  state_next = (|bus.req) ? ST_SWITCH : ST_IDLE;
               end else begin
                  state_next = ST_SHOW;
               end
            end
            ST_FLASH: begin
               if (!bus.alarm_flash) begin
                  state_next = ST_IDLE;
               end
            end
            default: begin
               grant_next = '0;
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Owner's digit word and blink mask
   always_comb begin
      owner_num   = '0;
      owner_blink = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            owner_num   = bus.num[16*i +: 16];
            owner_blink = bus.blink_sel[4*i +: 4];
         end
      end
   end

   assign owner_nib = owner_num[{digit, 2'b00} +: 4];

   bcd_seg_decode u_decode (
      .bcd (owner_nib),
      .seg (nib_seg)
   );

   // Pattern for the current digit given state, blink mask and blink phase
   always_comb begin
      anode_next = ANODE_OFF;
      seg_next   = SEG_BLANK;
      case (state)
         ST_SHOW: begin
            if (!(owner_blink[digit] && blink_phase)) begin
               anode_next = ~(4'b0001 << digit);
               seg_next   = nib_seg;
            end
         end
         ST_FLASH: begin
            if (!blink_phase) begin
               anode_next = 4'b0000;
               seg_next   = SEG_ALL;
            end
         end
         default: begin
            anode_next = ANODE_OFF;
            seg_next   = SEG_BLANK;
         end
      endcase
   end

   // Display register loaded once on a digit's first cycle so data cannot tear
   always_ff @(posedge clk) begin
      if (reset) begin
         anode_q <= ANODE_OFF;
         seg_q   <= SEG_BLANK;
      end else if (presc == '0) begin
         anode_q <= anode_next;
         seg_q   <= seg_next;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.anode      = anode_q;
   assign bus.eSeg       = seg_q;
   assign bus.frame_done = boundary;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter with a frame-level reference model.
module tb_display_arbiter;

   localparam int SD = 4;
   localparam int BF = 2;
   localparam int FR = 4 * SD;

   logic clk = 1'b0;
   logic reset = 1'b1;

   display_arbiter_if bus ();

   display_arbiter #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: cycle count since reset release, mode per frame
   // (0 idle, 1 blank changeover frame, 2 showing, 3 alarm flash), owner index.
   int         m_cyc, m_mode, m_owner;
   logic [3:0] e_grant, e_anode;
   logic [6:0] e_seg;
   logic       e_fd;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
      return v;
   endfunction

   // One clock: update model with the inputs present at the edge, settle.
   task automatic step();
      int pos, dig, sub, ph;
      logic [3:0] nib;
      @(posedge clk);
      if (reset) begin
         m_cyc = 0; m_mode = 0; m_owner = -1;
         e_anode = 4'b1111; e_seg = 7'b0;
      end else begin
         pos = m_cyc % FR;
         dig = pos / SD;
         sub = pos % SD;
         ph  = (m_cyc / FR / BF) % 2;
         if (sub == 0) begin
            e_anode = 4'b1111; e_seg = 7'b0;
            if (m_mode == 2) begin
               nib = bus.num[16*m_owner + 4*dig +: 4];
               if (!(bus.blink_sel[4*m_owner + dig] && ph == 1)) begin
                  e_anode = ~(4'b0001 << dig);
                  e_seg   = seg_of(nib);
               end
            end else if (m_mode == 3 && ph == 0) begin
               e_anode = 4'b0000; e_seg = 7'b1111111;
            end
         end
         if (pos == FR - 1) begin
            if (m_mode == 3) begin
               if (!bus.alarm_flash) m_mode = 0;
            end else if (bus.alarm_flash) begin
               m_mode = 3; m_owner = -1;
            end else if (m_owner < 0 || !bus.req[m_owner]) begin
               m_owner = -1;
               for (int i = 3; i >= 0; i--) if (bus.req[i]) m_owner = i;
               m_mode = (m_owner < 0) ? 0 : 1;
            end else if (m_mode == 1) begin
               m_mode = 2;
            end
         end
         m_cyc++;
      end
      e_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      e_fd    = ((m_cyc % FR) == FR - 1);
      #1;
   endtask

   task automatic test_reset();
      bus.req = 4'b0; bus.alarm_flash = 1'b0; bus.num = '0; bus.blink_sel = '0;
      reset = 1'b1; step(); reset = 1'b0;
      n_checks++;
      if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {4'b0000, 4'b1111, 7'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_values got grant=%b anode=%b eSeg=%b fd=%b want 0000 1111 0000000 0",
                  bus.grant, bus.anode, bus.eSeg, bus.frame_done);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {e_grant, e_anode, e_seg, e_fd}) begin
            n_err++;
            $display("FAIL idle_model cyc=%0d got %b %b %b %b want %b %b %b %b", m_cyc,
                     bus.grant, bus.anode, bus.eSeg, bus.frame_done, e_grant, e_anode, e_seg, e_fd);
         end
      end
   endtask

   task automatic test_basic_scan();
      logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0] sg_tab [4] = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
      int idx;
      bus.num = '0; bus.num[15:0] = 16'h1234; bus.req = 4'b0001; bus.blink_sel = '0;
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 48; i++) begin
         step();
         n_checks++;
         if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {e_grant, e_anode, e_seg, e_fd}) begin
            n_err++;
            $display("FAIL basic_model cyc=%0d got %b %b %b %b want %b %b %b %b", m_cyc,
                     bus.grant, bus.anode, bus.eSeg, bus.frame_done, e_grant, e_anode, e_seg, e_fd);
         end
         if (m_cyc == 15 || m_cyc == 16) begin
            n_checks++;
            if (bus.grant !== ((m_cyc == 16) ? 4'b0001 : 4'b0000)) begin
               n_err++;
               $display("FAIL basic_grant_edge cyc=%0d got %b", m_cyc, bus.grant);
            end
         end
         if (m_cyc >= 17 && m_cyc <= 32) begin
            n_checks++;
            if (bus.anode !== 4'b1111) begin
               n_err++;
               $display("FAIL basic_dark_frame cyc=%0d got anode=%b want 1111", m_cyc, bus.anode);
            end
         end
         if (m_cyc >= 33 && m_cyc <= 48) begin
            idx = (m_cyc - 33) / 4;
            n_checks++;
            if ({bus.anode, bus.eSeg} !== {an_tab[idx], sg_tab[idx]}) begin
               n_err++;
               $display("FAIL basic_digit cyc=%0d got %b/%b want %b/%b", m_cyc,
                        bus.anode, bus.eSeg, an_tab[idx], sg_tab[idx]);
            end
         end
      end
   endtask

   task automatic test_owner_drop();
      logic [3:0] want_an;
      bus.num = '0; bus.num[15:0] = rand_bcd(); bus.num[31:16] = rand_bcd();
      bus.req = 4'b0011; bus.blink_sel = '0;
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 80; i++) begin
         step();
         n_checks++;
         if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {e_grant, e_anode, e_seg, e_fd}) begin
            n_err++;
            $display("FAIL drop_model cyc=%0d got %b %b %b %b want %b %b %b %b", m_cyc,
                     bus.grant, bus.anode, bus.eSeg, bus.frame_done, e_grant, e_anode, e_seg, e_fd);
         end
         if (m_cyc == 40) bus.req = 4'b0010;
         if (m_cyc > 40) begin
            n_checks++;
            if (bus.grant !== ((m_cyc <= 47) ? 4'b0001 : 4'b0010)) begin
               n_err++;
               $display("FAIL drop_grant cyc=%0d got %b", m_cyc, bus.grant);
            end
         end
         if (m_cyc >= 49) begin
            want_an = (m_cyc <= 64) ? 4'b1111 : ~(4'b0001 << ((m_cyc - 65) / 4));
            n_checks++;
            if (bus.anode !== want_an) begin
               n_err++;
               $display("FAIL drop_anode cyc=%0d got %b want %b", m_cyc, bus.anode, want_an);
            end
         end
      end
   endtask

   task automatic test_alarm_flash();
      int lit;
      lit = 0;
      bus.num = '0; bus.num[15:0] = rand_bcd(); bus.req = 4'b0001; bus.blink_sel = '0;
      bus.alarm_flash = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 224; i++) begin
         step();
         n_checks++;
         if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {e_grant, e_anode, e_seg, e_fd}) begin
            n_err++;
            $display("FAIL alarm_model cyc=%0d got %b %b %b %b want %b %b %b %b", m_cyc,
                     bus.grant, bus.anode, bus.eSeg, bus.frame_done, e_grant, e_anode, e_seg, e_fd);
         end
         if (m_cyc == 40) bus.alarm_flash = 1'b1;
         if (m_cyc == 120) bus.alarm_flash = 1'b0;
         if (m_cyc == 170) begin bus.alarm_flash = 1'b1; bus.req = 4'b0000; end
         if (m_cyc >= 49 && m_cyc <= 128 && bus.anode === 4'b0000 && bus.eSeg === 7'b1111111) lit++;
         if (m_cyc >= 48 && m_cyc <= 144) begin
            n_checks++;
            if (bus.grant !== ((m_cyc == 144) ? 4'b0001 : 4'b0000)) begin
               n_err++;
               $display("FAIL alarm_grant cyc=%0d got %b", m_cyc, bus.grant);
            end
         end
      end
      bus.alarm_flash = 1'b0;
      n_checks++;
      if (lit !== 32) begin
         n_err++;
         $display("FAIL alarm_lit_cycles got %0d want 32", lit);
      end
   endtask

   task automatic test_blink();
      int cnt0, cnt2;
      cnt0 = 0; cnt2 = 0;
      bus.num = '0; bus.num[15:0] = rand_bcd(); bus.req = 4'b0001;
      bus.blink_sel = '0; bus.blink_sel[3:0] = 4'b0100; bus.alarm_flash = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 160; i++) begin
         step();
         n_checks++;
         if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {e_grant, e_anode, e_seg, e_fd}) begin
            n_err++;
            $display("FAIL blink_model cyc=%0d got %b %b %b %b want %b %b %b %b", m_cyc,
                     bus.grant, bus.anode, bus.eSeg, bus.frame_done, e_grant, e_anode, e_seg, e_fd);
         end
         if (bus.anode === 4'b1110) cnt0++;
         if (bus.anode === 4'b1011) cnt2++;
      end
      n_checks++;
      if (cnt0 !== 32 || cnt2 !== 16) begin
         n_err++;
         $display("FAIL blink_counts got d0=%0d d2=%0d want d0=32 d2=16", cnt0, cnt2);
      end
      bus.blink_sel = '0;
   endtask

   task automatic test_invalid_nibble();
      bus.num = '0; bus.num[15:0] = 16'h00A0; bus.req = 4'b0001;
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 48; i++) begin
         step();
         if (m_cyc >= 37 && m_cyc <= 40) begin
            n_checks++;
            if ({bus.anode, bus.eSeg} !== {4'b1101, 7'b0000000}) begin
               n_err++;
               $display("FAIL invalid_nibble cyc=%0d got %b/%b want 1101/0000000", m_cyc, bus.anode, bus.eSeg);
            end
         end
         if (m_cyc == 33) begin
            n_checks++;
            if ({bus.anode, bus.eSeg} !== {4'b1110, 7'b0111111}) begin
               n_err++;
               $display("FAIL invalid_zero_digit got %b/%b want 1110/0111111", bus.anode, bus.eSeg);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.num = '0; bus.num[15:0] = rand_bcd(); bus.req = 4'b0001;
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 40; i++) step();
      reset = 1'b1; step(); reset = 1'b0;
      n_checks++;
      if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {4'b0000, 4'b1111, 7'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_mid_values got %b %b %b %b want 0000 1111 0000000 0",
                  bus.grant, bus.anode, bus.eSeg, bus.frame_done);
      end
      for (int i = 0; i < 16; i++) begin
         step();
         if (m_cyc == 15 || m_cyc == 16) begin
            n_checks++;
            if (bus.grant !== ((m_cyc == 16) ? 4'b0001 : 4'b0000)) begin
               n_err++;
               $display("FAIL reset_mid_regrant cyc=%0d got %b", m_cyc, bus.grant);
            end
         end
      end
   endtask

   task automatic test_random();
      bus.req = 4'($urandom); bus.alarm_flash = 1'b0;
      bus.num = {$urandom, $urandom}; bus.blink_sel = 16'($urandom);
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(19, 0) == 0) bus.req = 4'($urandom);
         if ($urandom_range(79, 0) == 0) bus.alarm_flash = ~bus.alarm_flash;
         if ($urandom_range(29, 0) == 0) bus.num = {rand_bcd(), 16'($urandom), rand_bcd(), rand_bcd()};
         if ($urandom_range(39, 0) == 0) bus.blink_sel = 16'($urandom);
         step();
         n_checks++;
         if ({bus.grant, bus.anode, bus.eSeg, bus.frame_done} !== {e_grant, e_anode, e_seg, e_fd}) begin
            n_err++;
            $display("FAIL random_model cyc=%0d got %b %b %b %b want %b %b %b %b", m_cyc,
                     bus.grant, bus.anode, bus.eSeg, bus.frame_done, e_grant, e_anode, e_seg, e_fd);
         end
      end
   endtask

   initial begin
      bus.req = 4'b0; bus.alarm_flash = 1'b0; bus.num = '0; bus.blink_sel = '0;
      test_reset();
      test_basic_scan();
      test_owner_drop();
      test_alarm_flash();
      test_blink();
      test_invalid_nibble();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Owns the shared 4-digit seven-segment display and time-multiplexes it between the four service blocks (time set, alarm set, stopwatch, alarm/minigame). It arbitrates requests with sticky lowest-index priority and switches owners only at frame boundaries, inserting one blank frame on every change. It also runs the digit scan, per-digit blink and the alarm full-display flash. It replaces the ad-hoc owner muxing in the top level and drives `anode`/`eSeg` directly.

## Interface
- `SCAN_DIV`, 65536: clk cycles each digit is lit; must be ≥ 2.
- `BLINK_FRAMES`, 64: frames per blink half-period; must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `req`  in  4  display request; bit i = service i+1.
- `num`  in  64  BCD digits; `num[16i+15:16i]` belongs to requester i; nibble 0 = rightmost digit.
- `blink_sel`  in  16  `blink_sel[4i+3:4i]` = digits to blink for requester i.
- `alarm_flash`  in  1  alarm-ringing override.
- `grant`  out  4  one-hot current owner, or 0.
- `anode`  out  4  active-low digit enable; bit 0 = rightmost digit.
- `eSeg`  out  7  segment pattern (1 = lit, shared encoding table).
- `frame_done`  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation
- Scan path:
  - Prescaler counts 0..SCAN_DIV-1.
  - Digit index d (0..3) advances when the prescaler reaches SCAN_DIV-1 and wraps 3→0.
  - Frame boundary = prescaler==SCAN_DIV-1 and d==3. `frame_done` pulses on that cycle.
- Blink phase toggles after every BLINK_FRAMES frame boundaries.
- States: IDLE, SWITCH, SHOW, FLASH. Every transition happens only on a frame boundary.
- Arbitration winner = lowest set index of `req`.
- IDLE:
  - grant 0, anodes 1111.
  - Boundary: `alarm_flash` → FLASH; else any req → grant winner, go to SWITCH.
- SWITCH:
  - Grant held, anodes 1111 for exactly one frame.
  - Boundary: `alarm_flash` → FLASH; owner req low → re-arbitrate (SWITCH with new winner, or IDLE); else → SHOW.
- SHOW:
  - Digit d lights `anode` = ~(1<<d) and shows owner nibble d.
  - Digit d is blanked (anode 1111) when blink_sel[owner][d]=1 and blink phase=1.
  - Boundary: `alarm_flash` → FLASH with grant 0; owner req low → re-arbitrate as in SWITCH.
  - A higher-priority req does not preempt the owner.
- FLASH:
  - grant 0.
  - Blink phase 0: anode 0000, eSeg 1111111. Blink phase 1: anode 1111.
  - Boundary with `alarm_flash` low → IDLE.
- Nibble > 9 → eSeg 0000000 while its anode is active.
- Digit data for digit d is sampled once, when d is entered. No tearing within a digit.

## Timing
- Reset values:
  - grant 0000, anode 1111, eSeg 0000000, frame_done 0.
  - Internal: prescaler 0, d 0, blink phase 0, state IDLE.
- Reset mid-operation: all of the above on the same edge; outputs are dark the following cycle.
- `anode`/`eSeg` are registered and lag the internal digit index by one cycle.
- `grant` changes on the boundary edge, i.e. one frame (4·SCAN_DIV cycles) before the new owner's first lit digit.
- `req`/`alarm_flash` changes between boundaries are ignored until the next boundary.
- Simultaneous owner drop and other requests: the lowest-index remaining req wins.
- Simultaneous `alarm_flash` and owner drop: FLASH.
- The first frame boundary after reset release is 4·SCAN_DIV cycles later.

## Structure
- Shared package `display_pkg` holds:
  - NREQ=4.
  - The state enum.
  - SEG_PATTERN[0..9], SEG_BLANK, SEG_ALL.
  - ANODE_OFF=4'b1111.
- One sub-module, `bcd_seg_decode`: combinational 4-bit BCD → 7-bit pattern, blank on invalid input. It is reused by the service blocks.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_FRAMES=2.
- Basic grant and scan: reset, req=0001, num0=0x1234.
  - grant=0001 at cycle 16.
  - Frame 2 dark.
  - Frame 3: anode 1110/eSeg 1100110 for 4 cycles, then 1101/1001111, then 1011/1011011, then 0111/0000110.
- Owner drop: req=0011 from reset → grant 0001. Drop req[0] mid-frame.
  - grant stays 0001 until the boundary, then becomes 0010.
  - One dark frame, then num1 digits are shown.
- Alarm flash: in SHOW, pulse alarm_flash high for 5 frames.
  - At the boundary grant=0000.
  - anode 0000/eSeg 1111111 for 2 frames, dark for 2 frames, repeating.
  - After alarm_flash drops: IDLE, then re-grant.
- Blink: owner 0, blink_sel[3:0]=0100.
  - Digit 2 anode stays 1111 during alternate 2-frame windows.
  - Digits 0, 1, 3 are unaffected.
- Invalid nibble: num0=0x00A0 → eSeg 0000000 while anode=1101.
- Reset mid-SHOW: assert reset for 1 cycle.
  - Next cycle: anode 1111, eSeg 0, grant 0, frame_done 0.
  - With req still high, grant re-asserts 16 cycles after reset release.
